rom_load_arbiter: RTL and testbench

- Sits between the SPI system block's ROM byte stream (rom_loading / rom_do / rom_do_valid) and the single-port SDRAM controller.
- Packs loaded bytes into 16-bit little-endian words and buffers them in a small word FIFO.
- Issues the words as sequential SDRAM writes, and shares the SDRAM port with the running core's read/write requests.
- Guarantees no ROM byte is lost while keeping core accesses serviced.

---
 rtl/rom_load_arbiter.sv | 228 ++++++++++++++++++++++
 tb/tb_rom_load_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter: packs the SPI ROM byte stream into 16-bit little-endian
// words, buffers them in a small word FIFO and writes them to SDRAM. The
// single SDRAM port is shared with the running core.
//
// Build option: define ROM_CHECKSUM_EN to add the load_sum[15:0] output.
// It holds the wrapping sum of every accepted byte of the current session.
//
// Ports:
//   clk, resetn        system clock, asynchronous active-low reset
//   rom_loading        loading-session level from the SPI system block
//   rom_do/_valid      ROM byte and its one-cycle strobe
//   core_req/we/addr   core access request (level, held until core_ack)
//   core_din/dout      core write data / read data (valid with core_ack)
//   core_ack           one-cycle completion pulse to the core
//   mem_req/we/addr    SDRAM request, held stable until mem_ack
//   mem_din/dout       SDRAM write data / read data (valid with mem_ack)
//   mem_ack            one-cycle completion pulse from the SDRAM controller
//   load_done          one-cycle pulse once a session is completely written
//   load_overflow      sticky: a word was dropped because the FIFO was full
//   load_sum           (ROM_CHECKSUM_EN only) byte checksum of the session
module rom_load_arbiter #(
    parameter int            AW         = 22,
    parameter logic [AW-1:0] BASE_ADDR  = '0,
    parameter int            FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          rom_loading,
    input  logic [7:0]    rom_do,
    input  logic          rom_do_valid,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [15:0]   core_din,
    output logic [15:0]   core_dout,
    output logic          core_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout,
    input  logic          mem_ack,
    output logic          load_done,
`ifdef ROM_CHECKSUM_EN
    output logic [15:0]   load_sum,
`endif
    output logic          load_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic          owner_ld_q, owner_ld_d;
    logic          discard_q, discard_d;
    logic          loading_q, loading_d;
    logic          pack_valid_q, pack_valid_d;
    logic [7:0]    pack_byte_q, pack_byte_d;
    logic [15:0]   fifo_q [FIFO_DEPTH];
    logic [15:0]   fifo_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic          overflow_q, overflow_d;
    logic          session_q, session_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]   mem_din_q, mem_din_d;
    logic          core_ack_q, core_ack_d;
    logic [15:0]   core_dout_q, core_dout_d;

    logic          start, fall, ack, stale, pop;
    logic          byte_in, pend, push, accept, full;
    logic [15:0]   push_word;
    logic [CW-1:0] count_base;
    logic [PW-1:0] wr_base, rd_base;
    logic          core_ok, grant_ld, grant_core;

    // Session edges are taken against the registered previous level.
    assign loading_d = rom_loading;
    assign start     = rom_loading && !loading_q;
    assign fall      = !rom_loading && loading_q;

    // A loader write still in flight across a session start belongs to the
    // old session: its ack finishes the bus cycle but must not pop or count.
    assign ack   = (state_q == BUSY) && mem_ack;
    assign stale = discard_q || start;
    assign pop   = ack && owner_ld_q && !stale;

    // Byte packing; a session start discards any half-built word first.
    assign byte_in   = rom_loading && rom_do_valid;
    assign pend      = pack_valid_q && !start;
    assign push      = (byte_in && pend) || (fall && pack_valid_q);
    assign push_word = fall ? {8'h00, pack_byte_q} : {rom_do, pack_byte_q};

    // FIFO bookkeeping relative to the flushed state on a session start.
    assign count_base = start ? '0 : count_q;
    assign wr_base    = start ? '0 : wr_ptr_q;
    assign rd_base    = start ? '0 : rd_ptr_q;
    assign full       = count_base == CW'(FIFO_DEPTH);
    assign accept     = push && (!full || pop);

    // core_ack_q masks the core request that is still held high during
    // the ack cycle, so the finished access is not issued a second time.
    assign core_ok    = core_req && !core_ack_q;
    assign grant_ld   = (state_q == IDLE) && !start && (count_q != '0) &&
                        ((count_q >= CW'(FIFO_DEPTH - 1)) || !core_ok);
    assign grant_core = (state_q == IDLE) && !grant_ld && core_ok;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_ld_q   <= 1'b0;
            discard_q    <= 1'b0;
            loading_q    <= 1'b0;
            pack_valid_q <= 1'b0;
            pack_byte_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            waddr_q      <= BASE_ADDR;
            overflow_q   <= 1'b0;
            session_q    <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            core_ack_q   <= 1'b0;
            core_dout_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_ld_q   <= owner_ld_d;
            discard_q    <= discard_d;
            loading_q    <= loading_d;
            pack_valid_q <= pack_valid_d;
            pack_byte_q  <= pack_byte_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            waddr_q      <= waddr_d;
            overflow_q   <= overflow_d;
            session_q    <= session_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            core_ack_q   <= core_ack_d;
            core_dout_q  <= core_dout_d;
        end
    end

    // Word storage needs no reset: occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    // Next-state logic
    always_comb begin
        state_d    = (state_q == IDLE) ? ((grant_ld || grant_core) ? BUSY : IDLE)
                                       : (mem_ack ? IDLE : BUSY);
        owner_ld_d = (grant_ld || grant_core) ? grant_ld : owner_ld_q;
        discard_d  = (state_q == BUSY) && owner_ld_q && !mem_ack && (discard_q || start);
    end

    // Output logic: SDRAM request fields and core response
    always_comb begin
        mem_req_d   = grant_ld || grant_core || (mem_req_q && !ack);
        mem_we_d    = grant_ld ? 1'b1 : grant_core ? core_we : mem_we_q;
        mem_addr_d  = grant_ld ? waddr_q : grant_core ? core_addr : mem_addr_q;
        mem_din_d   = grant_ld ? fifo_q[rd_ptr_q] : grant_core ? core_din : mem_din_q;
        core_ack_d  = ack && !owner_ld_q;
        core_dout_d = (ack && !owner_ld_q) ? mem_dout : core_dout_q;
    end

    // Packing, FIFO and write-address datapath
    always_comb begin
        pack_valid_d = byte_in ? !pend : (pend && !fall);
        pack_byte_d  = (byte_in && !pend) ? rom_do : pack_byte_q;
        fifo_d       = fifo_q;
        if (accept)
            fifo_d[wr_base] = push_word;
        wr_ptr_d     = wr_base + PW'(accept);
        rd_ptr_d     = rd_base + PW'(pop);
        count_d      = count_base + CW'(accept) - CW'(pop);
        waddr_d      = start ? BASE_ADDR : waddr_q + AW'(pop);
        overflow_d   = !start && (overflow_q || (push && !accept));
        session_d    = start || (session_q && !load_done);
    end

    // Done once the level has dropped, the flush word (if any) is queued
    // and written, and no access is outstanding.
    assign load_done = session_q && !rom_loading && !loading_q && !pack_valid_q &&
                       (count_q == '0) && (state_q == IDLE);

`ifdef ROM_CHECKSUM_EN
    logic [15:0] sum_q, sum_d;

    // Summed per accepted word so bytes of a dropped word never count.
    always_comb begin
        sum_d = start ? 16'h0000
                      : sum_q + (accept ? {8'h00, push_word[7:0]} + {8'h00, push_word[15:8]}
                                        : 16'h0000);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign load_sum = sum_q;
`endif

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_din       = mem_din_q;
    assign core_ack      = core_ack_q;
    assign core_dout     = core_dout_q;
    assign load_overflow = overflow_q;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// tb_rom_load_arbiter: directed, table-driven bench for rom_load_arbiter with
// an SDRAM responder model that logs every completed access.
module tb_rom_load_arbiter;

    localparam int            AW   = 22;
    localparam logic [AW-1:0] BASE = 22'h000040;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rom_loading;
    logic [7:0]    rom_do;
    logic          rom_do_valid;
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [15:0]   core_din;
    logic [15:0]   core_dout;
    logic          core_ack;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [15:0]   mem_dout;
    logic          mem_ack;
    logic          load_done;
    logic          load_overflow;
`ifdef ROM_CHECKSUM_EN
    logic [15:0]   load_sum;
    logic [15:0]   sum_at_done;
`endif

    rom_load_arbiter #(.AW(AW), .BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn),
        .rom_loading(rom_loading), .rom_do(rom_do), .rom_do_valid(rom_do_valid),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_din(core_din), .core_dout(core_dout), .core_ack(core_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack),
        .load_done(load_done),
`ifdef ROM_CHECKSUM_EN
        .load_sum(load_sum),
`endif
        .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // SDRAM model state and access log
    int            ack_delay = 2;
    logic          ack_hold  = 1'b0;
    int            log_n     = 0;
    logic          log_we   [16];
    logic [AW-1:0] log_addr [16];
    logic [15:0]   log_data [16];
    int            done_cnt  = 0;

    typedef struct {
        int          n;
        logic [63:0] b;
        int          dly;
        int          nw;
        logic [63:0] w;
        logic [15:0] sum;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Responder: acks ack_delay cycles into each request unless held off.
    initial begin
        int cnt;
        cnt      = 0;
        mem_ack  = 1'b0;
        mem_dout = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack)
                mem_ack = 1'b0;
            else if (!mem_req)
                cnt = 0;
            else begin
                cnt++;
                if (!ack_hold && cnt >= ack_delay) begin
                    mem_ack  = 1'b1;
                    cnt      = 0;
                    mem_dout = 16'hBEEF ^ mem_addr[15:0];
                    if (log_n < 16) begin
                        log_we[log_n]   = mem_we;
                        log_addr[log_n] = mem_addr;
                        log_data[log_n] = mem_din;
                        log_n++;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (load_done) begin
                done_cnt++;
`ifdef ROM_CHECKSUM_EN
                sum_at_done = load_sum;
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        rom_do       = b;
        rom_do_valid = 1'b1;
        @(posedge clk);
        #1;
        rom_do_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        chk("load_done_once", done_cnt - d0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic run_session(input int idx);
        vec_t v;
        int   d0;
        v         = vecs[idx];
        ack_delay = v.dly;
        log_n     = 0;
        d0        = done_cnt;
        rom_loading = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.b[63-8*i -: 8]);
            @(posedge clk);
            #1;
        end
        rom_loading = 1'b0;
        wait_done(d0);
        chk($sformatf("v%0d_nwrites", idx), log_n, v.nw);
        for (int i = 0; i < v.nw; i++) begin
            chk($sformatf("v%0d_w%0d_data", idx, i), log_data[i], v.w[63-16*i -: 16]);
            chk($sformatf("v%0d_w%0d_addr", idx, i), log_addr[i], BASE + i);
            chk($sformatf("v%0d_w%0d_we", idx, i), log_we[i], 1);
        end
        chk($sformatf("v%0d_overflow", idx), load_overflow, 0);
`ifdef ROM_CHECKSUM_EN
        chk($sformatf("v%0d_sum", idx), sum_at_done, v.sum);
`endif
    endtask

    initial begin
        logic prev;
        logic got;
        logic saw;
        int   d0;
        int   k;

        // {bytes, byte stream (first byte in MSBs), ack delay, words, words (first in MSBs), sum}
        vecs[0] = '{4, 64'h1122_3344_0000_0000, 2, 2, 64'h2211_4433_0000_0000, 16'h00AA};
        vecs[1] = '{3, 64'hAABB_CC00_0000_0000, 2, 2, 64'hBBAA_00CC_0000_0000, 16'h0231};
        vecs[2] = '{6, 64'h0102_0304_0506_0000, 3, 3, 64'h0201_0403_0605_0000, 16'h0015};
        vecs[3] = '{1, 64'h5A00_0000_0000_0000, 1, 1, 64'h005A_0000_0000_0000, 16'h005A};
        vecs[4] = '{2, 64'hFF02_0000_0000_0000, 1, 1, 64'h02FF_0000_0000_0000, 16'h0101};
        vecs[5] = '{8, 64'h1020_3040_5060_7080, 1, 4, 64'h2010_4030_6050_8070, 16'h0240};

        resetn       = 1'b0;
        rom_loading  = 1'b0;
        rom_do       = '0;
        rom_do_valid = 1'b0;
        core_req     = 1'b0;
        core_we      = 1'b0;
        core_addr    = '0;
        core_din     = '0;

        repeat (3) @(negedge clk);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_core_ack", core_ack, 0);
        chk("rst_core_dout", core_dout, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_overflow", load_overflow, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++)
            run_session(i);

        // Core read competing with one buffered loader word: core goes first.
        log_n     = 0;
        ack_delay = 2;
        d0        = done_cnt;
        rom_loading = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h31);
        send_byte(8'h32);
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 22'h000100;
        @(negedge clk);
        chk("core_no_req_yet", mem_req, 0);
        @(negedge clk);
        chk("core_mem_req", mem_req, 1);
        chk("core_mem_we", mem_we, 0);
        chk("core_mem_addr", mem_addr, 22'h000100);
        prev = mem_ack;
        got  = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (core_ack) begin
                got = 1'b1;
                chk("core_ack_after_mem_ack", prev, 1);
                chk("core_dout", core_dout, 16'hBEEF ^ 16'h0100);
            end
            prev = mem_ack;
        end
        chk("core_ack_seen", got, 1);
        @(posedge clk);
        #1;
        core_req = 1'b0;
        @(negedge clk);
        chk("core_ack_one_cycle", core_ack, 0);
        @(posedge clk);
        #1;
        rom_loading = 1'b0;
        wait_done(d0);
        chk("core_log_n", log_n, 2);
        chk("core_log0_we", log_we[0], 0);
        chk("core_log0_addr", log_addr[0], 22'h000100);
        chk("core_log1_we", log_we[1], 1);
        chk("core_log1_addr", log_addr[1], BASE);
        chk("core_log1_data", log_data[1], 16'h3231);

        // Overflow with the SDRAM stalled, then a new session clears it.
        ack_hold  = 1'b1;
        ack_delay = 1;
        log_n     = 0;
        rom_loading = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 8; i++)
            send_byte(8'(i));
        @(negedge clk);
        chk("ovf_not_yet", load_overflow, 0);
        @(posedge clk);
        #1;
        send_byte(8'h09);
        send_byte(8'h0A);
        @(negedge clk);
        chk("ovf_set", load_overflow, 1);
`ifdef ROM_CHECKSUM_EN
        chk("ovf_sum_excludes_dropped", load_sum, 16'h0024);
`endif
        repeat (3) @(negedge clk);
        chk("ovf_sticky", load_overflow, 1);
        @(posedge clk);
        #1;
        rom_loading = 1'b0;
        @(posedge clk);
        #1;
        rom_loading = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("ovf_cleared_by_start", load_overflow, 0);
        chk("ovf_stale_still_busy", mem_req, 1);
`ifdef ROM_CHECKSUM_EN
        chk("ovf_sum_cleared", load_sum, 16'h0000);
`endif
        ack_hold = 1'b0;
        k = 0;
        while (log_n == 0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("stale_log_n", log_n, 1);
        chk("stale_data", log_data[0], 16'h0201);
        chk("stale_addr", log_addr[0], BASE);
        log_n = 0;
        d0    = done_cnt;
        @(posedge clk);
        #1;
        send_byte(8'h55);
        send_byte(8'h66);
        @(posedge clk);
        #1;
        rom_loading = 1'b0;
        wait_done(d0);
        chk("restart_log_n", log_n, 1);
        chk("restart_data", log_data[0], 16'h6655);
        chk("restart_addr", log_addr[0], BASE);
        chk("restart_overflow", load_overflow, 0);

        // Asynchronous reset in the middle of a loader write.
        log_n     = 0;
        ack_delay = 20;
        d0        = done_cnt;
        rom_loading = 1'b1;
        @(posedge clk);
        #1;
        send_byte(8'h77);
        send_byte(8'h88);
        k = 0;
        while (!mem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rstmid_busy", mem_req, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rstmid_mem_req", mem_req, 0);
        chk("rstmid_core_ack", core_ack, 0);
        chk("rstmid_load_done", load_done, 0);
        rom_loading = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        saw = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (mem_req)
                saw = 1'b1;
        end
        chk("rstmid_fifo_empty", saw, 0);
        chk("rstmid_no_write", log_n, 0);
        chk("rstmid_no_done", done_cnt - d0, 0);

        // Core write after reset confirms the FSM is back in IDLE.
        @(posedge clk);
        #1;
        ack_delay = 1;
        core_req  = 1'b1;
        core_we   = 1'b1;
        core_addr = 22'h000123;
        core_din  = 16'h5555;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (core_ack)
                got = 1'b1;
        end
        chk("post_rst_core_ack", got, 1);
        @(posedge clk);
        #1;
        core_req = 1'b0;
        chk("post_rst_log_n", log_n, 1);
        chk("post_rst_we", log_we[0], 1);
        chk("post_rst_addr", log_addr[0], 22'h000123);
        chk("post_rst_data", log_data[0], 16'h5555);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
